// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: credit-based drain of a registered-read FIFO into a valid/ready stream.
// Define FIFO_STREAM_READER_FORMAL_EN to compile in assertions and covers.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [15:0]      rd_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    logic [OW-1:0]    occ;
    logic             inflight;
    logic [PW-1:0]    head, tail;
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             pop;
    // Credit counts the word still on its way from the FIFO, so capture never needs a full check.
    assign fifo_ren = !rst && !fifo_empty && (occ + OW'(inflight) < OW'(BUF_DEPTH));
    assign m_valid  = !rst && occ != '0;
    assign m_data   = mem[head];
    assign pop      = m_valid && m_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            rd_count <= '0;
        end else begin
            inflight <= fifo_ren;
            if (inflight) begin
                mem[tail] <= fifo_rdata;
                tail      <= tail == PW'(BUF_DEPTH - 1) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head     <= head == PW'(BUF_DEPTH - 1) ? '0 : head + 1'b1;
                rd_count <= rd_count + 1'b1;
            end
            occ <= occ + OW'(inflight) - OW'(pop);
        end
    end
`ifdef FIFO_STREAM_READER_FORMAL_EN
    always_comb begin
        if (!rst) begin
            assert (!(fifo_ren && fifo_empty));
            assert (occ + OW'(inflight) <= OW'(BUF_DEPTH));
        end
    end
    assert property (@(posedge clk) disable iff (rst) m_valid && !m_ready |=> m_valid && $stable(m_data));
    assert property (@(posedge clk) rst |=> !m_valid);
    cover property (@(posedge clk) occ == OW'(BUF_DEPTH));
    cover property (@(posedge clk) occ == OW'(BUF_DEPTH) && pop);
`else
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model plus scoreboard around a depth-3 and a depth-2 reader.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fe0 = 1'b1, fe1 = 1'b1;
    logic [7:0]  rd0 = '0, rd1 = '0;
    logic        ren0, ren1, v0, v1;
    logic        rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0]  d0, d1;
    logic [15:0] cnt0, cnt1;
    logic        rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0]  fq0[$], fq1[$], exp_q[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .BUF_DEPTH(3)) u0 (
        .clk(clk), .rst(rst), .fifo_empty(fe0), .fifo_rdata(rd0), .fifo_ren(ren0),
        .m_valid(v0), .m_ready(rdy0), .m_data(d0), .rd_count(cnt0));
    fifo_stream_reader #(.WIDTH(8), .BUF_DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .fifo_empty(fe1), .fifo_rdata(rd1), .fifo_ren(ren1),
        .m_valid(v1), .m_ready(rdy1), .m_data(d1), .rd_count(cnt1));

    // FIFO model: read enable sampled mid-cycle, data registered on the following edge.
    always @(negedge clk) begin
        #2;
        rs0 = ren0;
        rs1 = ren1;
    end
    always @(posedge clk) begin
        if (rs0 && fq0.size() > 0) rd0 <= fq0.pop_front();
        if (rs1 && fq1.size() > 0) rd1 <= fq1.pop_front();
        fe0 <= fq0.size() == 0;
        fe1 <= fq1.size() == 0;
    end

    task automatic test_reset();
        fq0.push_back(8'h02);
        exp_q.push_back(8'h02);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            tests += 3;
            if (ren0 !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b expected 0", ren0); end
            if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", v0); end
            if (cnt0 !== 16'd0) begin fails++; $display("FAIL reset_count: got %h expected 0000", cnt0); end
        end
    endtask

    task automatic test_single();
        logic [7:0] e;
        @(negedge clk);
        rst = 1'b0;
        rdy0 = 1'b1;
        #1;
        tests++;
        if (ren0 !== 1'b1) begin fails++; $display("FAIL single_ren_c1: got %b expected 1", ren0); end
        @(negedge clk);
        #1;
        tests += 2;
        if (ren0 !== 1'b0) begin fails++; $display("FAIL single_ren_c2: got %b expected 0", ren0); end
        if (v0 !== 1'b0) begin fails++; $display("FAIL single_valid_c2: got %b expected 0", v0); end
        @(negedge clk);
        #1;
        tests++;
        if (v0 !== 1'b1) begin fails++; $display("FAIL single_valid_c3: got %b expected 1", v0); end
        if (v0 && rdy0) begin
            e = exp_q.pop_front();
            tests++;
            if (d0 !== e) begin fails++; $display("FAIL single_data: got %h expected %h", d0, e); end
        end
        @(negedge clk);
        #1;
        tests += 2;
        if (v0 !== 1'b0) begin fails++; $display("FAIL single_valid_c4: got %b expected 0", v0); end
        if (cnt0 !== 16'd1) begin fails++; $display("FAIL single_count: got %h expected 0001", cnt0); end
    endtask

    task automatic test_backpressure();
        int pulses = 0, got = 0;
        bit seen = 0;
        logic [7:0] held = '0, e;
        for (int i = 0; i < 5; i++) begin
            fq0.push_back(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rdy0 = 1'b0;
            #1;
            if (ren0) pulses++;
            if (v0 && !seen) begin seen = 1; held = d0; end
            else if (v0) begin
                tests++;
                if (d0 !== held) begin fails++; $display("FAIL bp_stable: got %h expected %h", d0, held); end
            end
        end
        tests += 4;
        if (pulses != 3) begin fails++; $display("FAIL bp_pulses: got %0d expected 3", pulses); end
        if (v0 !== 1'b1) begin fails++; $display("FAIL bp_full_valid: got %b expected 1", v0); end
        if (ren0 !== 1'b0) begin fails++; $display("FAIL bp_full_ren: got %b expected 0", ren0); end
        if (held !== exp_q[0]) begin fails++; $display("FAIL bp_head: got %h expected %h", held, exp_q[0]); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy0 = 1'b1;
            #1;
            if (v0 && rdy0) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL bp_extra: got %h expected none", d0); end
                else begin
                    e = exp_q.pop_front();
                    if (d0 !== e) begin fails++; $display("FAIL bp_data: got %h expected %h", d0, e); end
                end
            end
        end
        tests += 2;
        if (got != 5) begin fails++; $display("FAIL bp_words: got %0d expected 5", got); end
        if (cnt0 !== 16'd6) begin fails++; $display("FAIL bp_count: got %h expected 0006", cnt0); end
    endtask

    task automatic test_stream();
        int first_ren = -1, first_v = -1, last_v = -1, nv = 0;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            fq0.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rdy0 = 1'b1;
            #1;
            if (ren0 && first_ren < 0) first_ren = c;
            if (v0) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL stream_extra: got %h expected none", d0); end
                else begin
                    e = exp_q.pop_front();
                    if (d0 !== e) begin fails++; $display("FAIL stream_data: got %h expected %h", d0, e); end
                end
            end
        end
        tests += 4;
        if (nv != 16) begin fails++; $display("FAIL stream_words: got %0d expected 16", nv); end
        if (first_v != first_ren + 2) begin fails++; $display("FAIL stream_latency: got %0d expected %0d", first_v, first_ren + 2); end
        if (last_v - first_v != 15) begin fails++; $display("FAIL stream_gapless: got span %0d expected 15", last_v - first_v); end
        if (cnt0 !== 16'd22) begin fails++; $display("FAIL stream_count: got %h expected 0016", cnt0); end
    endtask

    task automatic test_reset_mid();
        int n = 0, got = 0;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) fq0.push_back(8'hA0 + 8'(i));
        for (int c = 0; c < 10 && n < 3; c++) begin
            @(negedge clk);
            rdy0 = 1'b0;
            #1;
            if (ren0) n++;
        end
        @(negedge clk);
        #1;
        tests += 2;
        if (v0 !== 1'b1) begin fails++; $display("FAIL mid_pre_valid: got %b expected 1", v0); end
        if (ren0 !== 1'b0) begin fails++; $display("FAIL mid_pre_ren: got %b expected 0", ren0); end
        rst = 1'b1;
        fq0.delete();
        #1;
        tests += 2;
        if (v0 !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", v0); end
        if (ren0 !== 1'b0) begin fails++; $display("FAIL mid_rst_ren: got %b expected 0", ren0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests += 2;
        if (v0 !== 1'b0) begin fails++; $display("FAIL mid_post_valid: got %b expected 0", v0); end
        if (cnt0 !== 16'd0) begin fails++; $display("FAIL mid_post_count: got %h expected 0000", cnt0); end
        for (int i = 0; i < 3; i++) begin
            fq0.push_back(8'hB0 + 8'(i));
            exp_q.push_back(8'hB0 + 8'(i));
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            rdy0 = 1'b1;
            #1;
            if (v0 && rdy0) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL mid_extra: got %h expected none", d0); end
                else begin
                    e = exp_q.pop_front();
                    if (d0 !== e) begin fails++; $display("FAIL mid_data: got %h expected %h", d0, e); end
                end
            end
        end
        tests += 2;
        if (got != 3) begin fails++; $display("FAIL mid_words: got %0d expected 3", got); end
        if (cnt0 !== 16'd3) begin fails++; $display("FAIL mid_count: got %h expected 0003", cnt0); end
    endtask

    task automatic test_half_rate();
        int first_ren = -1, first_v = -1, last_v = -1, nv = 0;
        logic [7:0] e;
        for (int i = 0; i < 8; i++) begin
            fq1.push_back(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            rdy1 = 1'b1;
            #1;
            if (ren1 && first_ren < 0) first_ren = c;
            if (v1) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
                tests++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL half_extra: got %h expected none", d1); end
                else begin
                    e = exp_q.pop_front();
                    if (d1 !== e) begin fails++; $display("FAIL half_data: got %h expected %h", d1, e); end
                end
            end
        end
        tests += 5;
        if (nv != 8) begin fails++; $display("FAIL half_words: got %0d expected 8", nv); end
        if (first_v != first_ren + 2) begin fails++; $display("FAIL half_latency: got %0d expected %0d", first_v, first_ren + 2); end
        if (last_v - first_ren > 15) begin fails++; $display("FAIL half_window: got %0d cycles expected at most 16", last_v - first_ren + 1); end
        if (last_v - first_v <= 7) begin fails++; $display("FAIL half_rate: got span %0d expected above 7", last_v - first_v); end
        if (cnt1 !== 16'd8) begin fails++; $display("FAIL half_count: got %h expected 0008", cnt1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_half_rate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
